// File: rtl/rs_pkg.sv
// Shared types and constants for the age-ordered ALU reservation station.
// The default widths below are the reference configuration used by the station.
package rs_pkg;

    localparam int NO_DEP      = 0;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_NUM_CDB = 2;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_OP_W    = 5;

    typedef struct packed {
        logic                  busy;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_TAG_W-1:0]  dest;
        logic [DEF_DATA_W-1:0] vj;
        logic [DEF_DATA_W-1:0] vk;
        logic [DEF_TAG_W-1:0]  qj;
        logic [DEF_TAG_W-1:0]  qk;
    } rs_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] value;
    } cdb_port_t;

endpackage

// File: rtl/rs_age_ordered_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
// older_in[i*DEPTH + j] = 1 means entry i is older than entry j.
module oldest_ready_select
    import rs_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic [DEPTH-1:0]         ready_in,
    input  logic [DEPTH*DEPTH-1:0]   older_in,
    output logic [$clog2(DEPTH)-1:0] sel_idx,
    output logic                     sel_valid
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] grant;

    // The age matrix is a total order over busy entries, so grant is one-hot whenever any entry is ready.
    always_comb begin
        grant = ready_in;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_in[j] && older_in[j*DEPTH + i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_idx = sel_idx | IDX_W'(i);
            end
        end
    end

    assign sel_valid = |ready_in;

endmodule

// File: rtl/rs_age_ordered.sv
// ALU reservation station: CDB wakeup with dispatch bypass, lowest-free-slot allocation,
// and oldest-ready issue selection through an age matrix.
module rs_age_ordered
    import rs_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      disp_valid,
    input  logic [OP_W-1:0]           disp_op,
    input  logic [TAG_W-1:0]          disp_dest,
    input  logic [DATA_W-1:0]         disp_Vj,
    input  logic [DATA_W-1:0]         disp_Vk,
    input  logic [TAG_W-1:0]          disp_Qj,
    input  logic [TAG_W-1:0]          disp_Qk,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic                      full,
    output logic                      almost_full,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [OP_W-1:0]           issue_op,
    output logic [TAG_W-1:0]          issue_dest,
    output logic [DATA_W-1:0]         issue_Vj,
    output logic [DATA_W-1:0]         issue_Vk
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } slot_t;

    typedef struct packed {
        logic [TAG_W-1:0]  q;
        logic [DATA_W-1:0] v;
    } opnd_t;

    slot_t            slot_q  [DEPTH];
    slot_t            slot_d  [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    logic [DEPTH-1:0]       ready;
    logic [DEPTH*DEPTH-1:0] older_flat;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W:0]         free_cnt;
    logic                   issue_fire;
    logic                   disp_fire;

    // Lowest matching port wins, so scan from the highest port down and let later hits overwrite.
    function automatic opnd_t snoop(
        input opnd_t                     o,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  t,
        input logic [NUM_CDB*DATA_W-1:0] d
    );
        opnd_t r;
        r = o;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (v[p] && (o.q != TAG_W'(NO_DEP)) && (t[p*TAG_W +: TAG_W] == o.q)) begin
                r.q = TAG_W'(NO_DEP);
                r.v = d[p*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    always_comb begin
        ready      = '0;
        older_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && (slot_q[i].qj == TAG_W'(NO_DEP))
                                 && (slot_q[i].qk == TAG_W'(NO_DEP));
            older_flat[i*DEPTH +: DEPTH] = older_q[i];
        end
    end

    oldest_ready_select #(
        .DEPTH(DEPTH)
    ) u_select (
        .ready_in (ready),
        .older_in (older_flat),
        .sel_idx  (sel_idx),
        .sel_valid(sel_valid)
    );

    always_comb begin
        free_cnt = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_cnt = free_cnt + (IDX_W + 1)'(!busy_q[i]);
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full        = (free_cnt == '0);
    assign almost_full = (free_cnt == (IDX_W + 1)'(1));

    assign issue_valid = rdy_in && sel_valid;
    assign issue_op    = issue_valid ? slot_q[sel_idx].op   : '0;
    assign issue_dest  = issue_valid ? slot_q[sel_idx].dest : '0;
    assign issue_Vj    = issue_valid ? slot_q[sel_idx].vj   : '0;
    assign issue_Vk    = issue_valid ? slot_q[sel_idx].vk   : '0;

    assign issue_fire = issue_valid && issue_ready;
    assign disp_fire  = rdy_in && disp_valid && !full;

    // The new entry's column is taken from busy_d after the issue clear, so a slot freed
    // this cycle never ends up marked older than the newcomer.
    always_comb begin
        busy_d  = busy_q;
        slot_d  = slot_q;
        older_d = older_q;
        if (flush_in) begin
            busy_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_d[i] = '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i]) begin
                    {slot_d[i].qj, slot_d[i].vj} = snoop({slot_q[i].qj, slot_q[i].vj},
                                                         cdb_valid, cdb_tag, cdb_value);
                    {slot_d[i].qk, slot_d[i].vk} = snoop({slot_q[i].qk, slot_q[i].vk},
                                                         cdb_valid, cdb_tag, cdb_value);
                end
            end
            if (issue_fire) begin
                busy_d[sel_idx]  = 1'b0;
                older_d[sel_idx] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    older_d[i][sel_idx] = 1'b0;
                end
            end
            if (disp_fire) begin
                slot_d[free_idx].op   = disp_op;
                slot_d[free_idx].dest = disp_dest;
                {slot_d[free_idx].qj, slot_d[free_idx].vj} = snoop({disp_Qj, disp_Vj},
                                                                   cdb_valid, cdb_tag, cdb_value);
                {slot_d[free_idx].qk, slot_d[free_idx].vk} = snoop({disp_Qk, disp_Vk},
                                                                   cdb_valid, cdb_tag, cdb_value);
                older_d[free_idx] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    older_d[i][free_idx] = busy_d[i];
                end
                busy_d[free_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
                slot_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= older_d[i];
                slot_q[i]  <= slot_d[i];
            end
        end
    end

endmodule
